// File: rtl/ten_gig_arb_pkg.sv
// Shared types and constants for the 10G TX packet arbiter and its round-robin picker.
package ten_gig_arb_pkg;

    localparam int unsigned AXIS_DW = 64;
    localparam int unsigned AXIS_KW = AXIS_DW / 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ARB   = 3'd1;
    localparam state_t ST_XFER  = 3'd2;
    localparam state_t ST_ABORT = 3'd3;
    localparam state_t ST_DRAIN = 3'd4;

    // Beat presented to the channel when a packet is cut short by link loss
    localparam logic [AXIS_KW-1:0] ABORT_TKEEP = 8'h01;
    localparam logic [AXIS_DW-1:0] ABORT_TDATA = '0;

    function automatic int unsigned calc_max_beats(input int unsigned max_length);
        return (max_length + 7) / 8;
    endfunction

    function automatic int unsigned calc_cnt_w(input int unsigned max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/ten_gig_tx_arbiter_if.sv
// AXI-Stream bundle between P_REQ_NUM sources, the arbiter and the channel TX port.
interface ten_gig_tx_arbiter_if #(
    parameter int unsigned P_REQ_NUM = 4
);
    logic [P_REQ_NUM-1:0]                            s_axis_tvalid;
    logic [P_REQ_NUM-1:0]                            s_axis_tready;
    logic [ten_gig_arb_pkg::AXIS_DW*P_REQ_NUM-1:0]   s_axis_tdata;
    logic [ten_gig_arb_pkg::AXIS_KW*P_REQ_NUM-1:0]   s_axis_tkeep;
    logic [P_REQ_NUM-1:0]                            s_axis_tlast;
    logic [P_REQ_NUM-1:0]                            s_axis_tuser;

    logic                                            m_axis_tready;
    logic                                            m_axis_tvalid;
    logic [ten_gig_arb_pkg::AXIS_DW-1:0]             m_axis_tdata;
    logic [ten_gig_arb_pkg::AXIS_KW-1:0]             m_axis_tkeep;
    logic                                            m_axis_tlast;
    logic                                            m_axis_tuser;

    // Arbiter side
    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser
    );

    // Sources and channel side
    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after i_ptr in cyclic order.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW-1:0] w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_cand = IW'((32'(i_ptr) + i) % N);
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ten_gig_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one 10G TX AXI-Stream port between local sources;
// cuts packets cleanly on oversize or link loss and drains the remainder of the source packet.
module ten_gig_tx_arbiter
    import ten_gig_arb_pkg::*;
#(
    parameter int unsigned  P_REQ_NUM    = 4,
    parameter logic [14:0]  P_MAX_LENGTH = 15'd9600
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_link_up,
    ten_gig_tx_arbiter_if.slave  axis,
    output logic [P_REQ_NUM-1:0] o_grant,
    output logic                 o_busy,
    output logic [15:0]          o_abort_cnt
);

    localparam int unsigned IW          = $clog2(P_REQ_NUM);
    localparam int unsigned P_MAX_BEATS = calc_max_beats(32'(P_MAX_LENGTH));
    localparam int unsigned CW          = calc_cnt_w(P_MAX_BEATS);
    localparam logic [CW-1:0] LAST_BEAT_CNT = CW'(P_MAX_BEATS - 1);

    state_t               r_state;
    state_t               w_next;
    logic [P_REQ_NUM-1:0] r_grant;
    logic [IW-1:0]        r_gidx;
    logic [IW-1:0]        r_ptr;
    logic [CW-1:0]        r_beat_cnt;
    logic [15:0]          r_abort_cnt;

    logic [P_REQ_NUM-1:0] w_arb_gnt;
    logic [IW-1:0]        w_arb_idx;
    logic                 w_arb_any;

    logic                 w_src_valid;
    logic                 w_src_last;
    logic                 w_src_user;
    logic [AXIS_DW-1:0]   w_src_data;
    logic [AXIS_KW-1:0]   w_src_keep;

    logic                 w_force_end;
    logic                 w_m_hs;
    logic                 w_oversize;
    logic                 w_abort_hs;

    rr_arbiter #(
        .N  (P_REQ_NUM),
        .IW (IW)
    ) u_rr (
        .i_req (axis.s_axis_tvalid),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    // Select the granted source's stream
    always_comb begin
        w_src_valid = 1'b0;
        w_src_last  = 1'b0;
        w_src_user  = 1'b0;
        w_src_data  = '0;
        w_src_keep  = '0;
        for (int unsigned k = 0; k < P_REQ_NUM; k++) begin
            if (r_gidx == IW'(k)) begin
                w_src_valid = axis.s_axis_tvalid[k];
                w_src_last  = axis.s_axis_tlast[k];
                w_src_user  = axis.s_axis_tuser[k];
                w_src_data  = axis.s_axis_tdata[k*AXIS_DW +: AXIS_DW];
                w_src_keep  = axis.s_axis_tkeep[k*AXIS_KW +: AXIS_KW];
            end
        end
    end

    // Link loss takes priority over the handshake, so no beat moves in that cycle
    assign w_force_end = (r_beat_cnt == LAST_BEAT_CNT) && !w_src_last;
    assign w_m_hs      = (r_state == ST_XFER) && i_link_up && w_src_valid && axis.m_axis_tready;
    assign w_oversize  = w_m_hs && w_force_end;
    assign w_abort_hs  = (r_state == ST_ABORT) && axis.m_axis_tready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_link_up && |axis.s_axis_tvalid) w_next = ST_ARB;
            ST_ARB:   w_next = (i_link_up && w_arb_any) ? ST_XFER : ST_IDLE;
            ST_XFER: begin
                if (!i_link_up)            w_next = (r_beat_cnt != '0) ? ST_ABORT : ST_DRAIN;
                else if (w_m_hs && w_src_last) w_next = ST_IDLE;
                else if (w_oversize)       w_next = ST_DRAIN;
            end
            ST_ABORT: if (axis.m_axis_tready) w_next = ST_DRAIN;
            ST_DRAIN: if (w_src_valid && w_src_last) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        axis.s_axis_tready = '0;
        axis.m_axis_tvalid = 1'b0;
        axis.m_axis_tdata  = '0;
        axis.m_axis_tkeep  = '0;
        axis.m_axis_tlast  = 1'b0;
        axis.m_axis_tuser  = 1'b0;
        case (r_state)
            ST_XFER: begin
                if (i_link_up) begin
                    axis.s_axis_tready = r_grant & {P_REQ_NUM{axis.m_axis_tready}};
                    axis.m_axis_tvalid = w_src_valid;
                    axis.m_axis_tdata  = w_src_data;
                    axis.m_axis_tkeep  = w_src_keep;
                    axis.m_axis_tlast  = w_src_last | w_force_end;
                    axis.m_axis_tuser  = w_src_user | w_force_end;
                end
            end
            ST_ABORT: begin
                axis.m_axis_tvalid = 1'b1;
                axis.m_axis_tdata  = ABORT_TDATA;
                axis.m_axis_tkeep  = ABORT_TKEEP;
                axis.m_axis_tlast  = 1'b1;
                axis.m_axis_tuser  = 1'b1;
            end
            ST_DRAIN: axis.s_axis_tready = r_grant;
            default: ;
        endcase
    end

    // Grant, round-robin pointer, beat counter and abort statistics
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant     <= '0;
            r_gidx      <= '0;
            r_ptr       <= '0;
            r_beat_cnt  <= '0;
            r_abort_cnt <= '0;
        end else begin
            if (r_state == ST_ARB && w_next == ST_XFER) begin
                r_grant    <= w_arb_gnt;
                r_gidx     <= w_arb_idx;
                r_ptr      <= (w_arb_idx == IW'(P_REQ_NUM - 1)) ? '0 : w_arb_idx + IW'(1);
                r_beat_cnt <= '0;
            end else if (w_next == ST_IDLE) begin
                r_grant <= '0;
            end
            if (w_m_hs) r_beat_cnt <= r_beat_cnt + CW'(1);
            if ((w_oversize || w_abort_hs) && r_abort_cnt != 16'hFFFF)
                r_abort_cnt <= r_abort_cnt + 16'd1;
        end
    end

    assign o_grant     = r_grant;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_abort_cnt = r_abort_cnt;

endmodule

// File: tb/tb_ten_gig_tx_arbiter.sv
// Directed scoreboard bench for ten_gig_tx_arbiter: sources replay queued beats,
// a monitor pops expected channel beats on every output handshake.
module tb_ten_gig_tx_arbiter;

    localparam int NSRC      = 4;
    localparam int MAX_BEATS = 1200;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } src_beat_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
        logic [3:0]  grant;
        logic [7:0]  gap;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        link_up;
    logic [3:0]  grant;
    logic        busy;
    logic [15:0] abort_cnt;

    ten_gig_tx_arbiter_if #(.P_REQ_NUM(NSRC)) axis_if ();

    ten_gig_tx_arbiter #(
        .P_REQ_NUM    (NSRC),
        .P_MAX_LENGTH (15'd9600)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_link_up   (link_up),
        .axis        (axis_if),
        .o_grant     (grant),
        .o_busy      (busy),
        .o_abort_cnt (abort_cnt)
    );

    src_beat_t src_q[NSRC][$];
    beat_t     exp_q[$];
    int        n_vec    = 0;
    int        n_err    = 0;
    int        hs_count = 0;
    int        cyc      = 0;
    int        last_cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] mkdata(input int src, input int pkt, input int beat);
        return {4'hA, 4'(src), 8'(pkt), 16'(beat), 32'h5A5A_0000 ^ 32'(beat * 7)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_src(input int src, input int pkt, input int nbeats, input logic [7:0] last_keep);
        src_beat_t sb;
        for (int b = 0; b < nbeats; b++) begin
            sb.data = mkdata(src, pkt, b);
            sb.keep = (b == nbeats - 1) ? last_keep : 8'hFF;
            sb.last = (b == nbeats - 1);
            sb.user = 1'b0;
            src_q[src].push_back(sb);
        end
    endtask

    task automatic expect_pkt(input int src, input int pkt, input int nbeats,
                              input logic [7:0] last_keep, input int first_gap);
        beat_t e;
        for (int b = 0; b < nbeats; b++) begin
            e.data  = mkdata(src, pkt, b);
            e.keep  = (b == nbeats - 1) ? last_keep : 8'hFF;
            e.last  = (b == nbeats - 1);
            e.user  = 1'b0;
            e.grant = 4'(1 << src);
            e.gap   = (b == 0) ? 8'(first_gap) : 8'd1;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_exp(input int max_cyc, input string name);
        int i = 0;
        while (exp_q.size() != 0 && i < max_cyc) begin
            @(negedge clk); #1;
            i++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic wait_src(input int src, input int max_cyc, input string name);
        int i = 0;
        while (src_q[src].size() != 0 && i < max_cyc) begin
            @(negedge clk); #1;
            i++;
        end
        chk(name, 64'(src_q[src].size()), 64'd0);
    endtask

    task automatic wait_grant(input logic [3:0] g, input int max_cyc, input string name);
        int i = 0;
        while (grant !== g && i < max_cyc) begin
            @(negedge clk); #1;
            i++;
        end
        chk(name, 64'(grant), 64'(g));
    endtask

    // Source models: hold each beat until its handshake, then present the next
    initial begin : drv
        logic [NSRC-1:0] hs;
        axis_if.s_axis_tvalid = '0;
        axis_if.s_axis_tdata  = '0;
        axis_if.s_axis_tkeep  = '0;
        axis_if.s_axis_tlast  = '0;
        axis_if.s_axis_tuser  = '0;
        forever begin
            @(negedge clk);
            hs = axis_if.s_axis_tvalid & axis_if.s_axis_tready;
            @(posedge clk); #1;
            for (int k = 0; k < NSRC; k++) begin
                if (hs[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
                if (src_q[k].size() > 0) begin
                    axis_if.s_axis_tvalid[k]          = 1'b1;
                    axis_if.s_axis_tdata[k*64 +: 64]  = src_q[k][0].data;
                    axis_if.s_axis_tkeep[k*8 +: 8]    = src_q[k][0].keep;
                    axis_if.s_axis_tlast[k]           = src_q[k][0].last;
                    axis_if.s_axis_tuser[k]           = src_q[k][0].user;
                end else begin
                    axis_if.s_axis_tvalid[k]          = 1'b0;
                    axis_if.s_axis_tdata[k*64 +: 64]  = '0;
                    axis_if.s_axis_tkeep[k*8 +: 8]    = '0;
                    axis_if.s_axis_tlast[k]           = 1'b0;
                    axis_if.s_axis_tuser[k]           = 1'b0;
                end
            end
        end
    end

    // Channel-side monitor: every output handshake pops one expected beat
    initial begin : mon
        beat_t e;
        beat_t a;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && axis_if.m_axis_tvalid && axis_if.m_axis_tready) begin
                hs_count++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat: got data 0x%0h last %0b grant %b, required no beat",
                             axis_if.m_axis_tdata, axis_if.m_axis_tlast, grant);
                end else begin
                    e       = exp_q.pop_front();
                    a.data  = axis_if.m_axis_tdata;
                    a.keep  = axis_if.m_axis_tkeep;
                    a.last  = axis_if.m_axis_tlast;
                    a.user  = axis_if.m_axis_tuser;
                    a.grant = grant;
                    a.gap   = (e.gap == 8'd0) ? 8'd0 : 8'(cyc - last_cyc);
                    if (a !== e) begin
                        n_err++;
                        $display("FAIL out_beat %0d: got data=%h keep=%h last=%b user=%b grant=%b gap=%0d, required data=%h keep=%h last=%b user=%b grant=%b gap=%0d",
                                 hs_count, a.data, a.keep, a.last, a.user, a.grant, a.gap,
                                 e.data, e.keep, e.last, e.user, e.grant, e.gap);
                    end
                end
                last_cyc = cyc;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        beat_t e;
        int    base;
        int    i;
        rst_n   = 1'b0;
        link_up = 1'b0;
        axis_if.m_axis_tready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid",  64'(axis_if.m_axis_tvalid), 64'd0);
        chk("rst_m_tlast",   64'(axis_if.m_axis_tlast),  64'd0);
        chk("rst_m_tuser",   64'(axis_if.m_axis_tuser),  64'd0);
        chk("rst_m_tdata",   axis_if.m_axis_tdata,       64'd0);
        chk("rst_m_tkeep",   64'(axis_if.m_axis_tkeep),  64'd0);
        chk("rst_s_tready",  64'(axis_if.s_axis_tready), 64'd0);
        chk("rst_grant",     64'(grant),                 64'd0);
        chk("rst_busy",      64'(busy),                  64'd0);
        chk("rst_abort_cnt", 64'(abort_cnt),             64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Link down with every source requesting: nothing may start
        load_src(0, 0, 3, 8'hFF);
        load_src(1, 0, 3, 8'hFF);
        load_src(2, 0, 3, 8'hFF);
        load_src(3, 0, 3, 8'hFF);
        load_src(0, 1, 3, 8'hFF);
        repeat (5) @(negedge clk);
        #1;
        chk("linkdown_busy",     64'(busy),                  64'd0);
        chk("linkdown_s_tready", 64'(axis_if.s_axis_tready), 64'd0);
        chk("linkdown_m_tvalid", 64'(axis_if.m_axis_tvalid), 64'd0);

        // Round-robin 0,1,2,3,0 with 2 idle cycles between packets
        expect_pkt(0, 0, 3, 8'hFF, 0);
        expect_pkt(1, 0, 3, 8'hFF, 3);
        expect_pkt(2, 0, 3, 8'hFF, 3);
        expect_pkt(3, 0, 3, 8'hFF, 3);
        expect_pkt(0, 1, 3, 8'hFF, 3);
        @(posedge clk); #1;
        link_up = 1'b1;
        axis_if.m_axis_tready = 1'b1;
        wait_exp(200, "rr_burst_done");
        repeat (3) @(negedge clk);
        #1;
        chk("rr_grant_idle", 64'(grant), 64'd0);

        // Single-beat packet stalled by channel back-pressure
        @(posedge clk); #1;
        axis_if.m_axis_tready = 1'b0;
        load_src(2, 2, 1, 8'h0F);
        expect_pkt(2, 2, 1, 8'h0F, 0);
        wait_grant(4'b0100, 50, "stall_grant");
        chk("stall1_s_tready", 64'(axis_if.s_axis_tready), 64'd0);
        chk("stall1_m_tvalid", 64'(axis_if.m_axis_tvalid), 64'd1);
        @(negedge clk); #1;
        chk("stall2_s_tready", 64'(axis_if.s_axis_tready), 64'd0);
        chk("stall2_grant",    64'(grant),                 64'h4);
        @(posedge clk); #1;
        axis_if.m_axis_tready = 1'b1;
        wait_exp(50, "stall_done");
        repeat (3) @(negedge clk);
        #1;
        chk("stall_grant_idle", 64'(grant), 64'd0);

        // Oversize: 1300-beat packet truncated at beat 1200, remainder drained
        load_src(1, 3, 1300, 8'hFF);
        for (int b = 0; b < MAX_BEATS; b++) begin
            e.data  = mkdata(1, 3, b);
            e.keep  = 8'hFF;
            e.last  = (b == MAX_BEATS - 1);
            e.user  = (b == MAX_BEATS - 1);
            e.grant = 4'b0010;
            e.gap   = (b == 0) ? 8'd0 : 8'd1;
            exp_q.push_back(e);
        end
        wait_src(1, 3000, "oversize_src_drained");
        wait_exp(10, "oversize_out_done");
        repeat (3) @(negedge clk);
        #1;
        chk("oversize_abort_cnt", 64'(abort_cnt), 64'd1);
        chk("oversize_busy",      64'(busy),      64'd0);
        chk("oversize_grant",     64'(grant),     64'd0);

        // Link loss after 5 of 8 beats: abort beat then drain
        load_src(0, 4, 8, 8'hFF);
        for (int b = 0; b < 5; b++) begin
            e.data  = mkdata(0, 4, b);
            e.keep  = 8'hFF;
            e.last  = 1'b0;
            e.user  = 1'b0;
            e.grant = 4'b0001;
            e.gap   = (b == 0) ? 8'd0 : 8'd1;
            exp_q.push_back(e);
        end
        e.data  = 64'd0;
        e.keep  = 8'h01;
        e.last  = 1'b1;
        e.user  = 1'b1;
        e.grant = 4'b0001;
        e.gap   = 8'd2;
        exp_q.push_back(e);
        base = hs_count;
        i    = 0;
        while (hs_count < base + 5 && i < 100) begin
            @(negedge clk); #1;
            i++;
        end
        chk("linkloss_5_beats_seen", 64'(hs_count - base), 64'd5);
        @(posedge clk); #1;
        link_up = 1'b0;
        wait_src(0, 100, "linkloss_src_drained");
        wait_exp(10, "linkloss_out_done");
        load_src(2, 5, 2, 8'h3F);
        repeat (3) @(negedge clk);
        #1;
        chk("linkloss_abort_cnt", 64'(abort_cnt),             64'd2);
        chk("linkloss_busy",      64'(busy),                  64'd0);
        chk("linkloss_grant",     64'(grant),                 64'd0);
        chk("linkloss_s_tready",  64'(axis_if.s_axis_tready), 64'd0);
        chk("linkloss_m_tvalid",  64'(axis_if.m_axis_tvalid), 64'd0);
        expect_pkt(2, 5, 2, 8'h3F, 0);
        @(posedge clk); #1;
        link_up = 1'b1;
        wait_exp(50, "link_return_done");

        // Asynchronous reset in the middle of a granted packet
        @(posedge clk); #1;
        axis_if.m_axis_tready = 1'b0;
        load_src(3, 6, 4, 8'hFF);
        wait_grant(4'b1000, 50, "prereset_grant");
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_m_tvalid",  64'(axis_if.m_axis_tvalid), 64'd0);
        chk("midrst_m_tdata",   axis_if.m_axis_tdata,       64'd0);
        chk("midrst_s_tready",  64'(axis_if.s_axis_tready), 64'd0);
        chk("midrst_grant",     64'(grant),                 64'd0);
        chk("midrst_busy",      64'(busy),                  64'd0);
        chk("midrst_abort_cnt", 64'(abort_cnt),             64'd0);
        load_src(0, 7, 2, 8'h07);
        expect_pkt(0, 7, 2, 8'h07, 0);
        expect_pkt(3, 6, 4, 8'hFF, 3);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        axis_if.m_axis_tready = 1'b1;
        wait_exp(100, "postreset_done");

        repeat (3) @(negedge clk);
        #1;
        chk("final_grant", 64'(grant), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
